// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared face/axis encodings for the DDA stepper, face encoder and shading LUT
package ray_pkg;

   typedef enum logic [2:0] {
      FACE_POS_X  = 3'b000,
      FACE_NEG_X  = 3'b001,
      FACE_POS_Y  = 3'b010,
      FACE_NEG_Y  = 3'b011,
      FACE_POS_Z  = 3'b100,
      FACE_NEG_Z  = 3'b101,
      FACE_INSIDE = 3'b110,
      FACE_MISS   = 3'b111
   } face_t;

   typedef enum logic [1:0] {
      AXIS_X       = 2'd0,
      AXIS_Y       = 2'd1,
      AXIS_Z       = 2'd2,
      AXIS_ILLEGAL = 2'd3
   } axis_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACE = 2'd1,
      ST_HOLD  = 2'd2
   } enc_state_t;

endpackage

// File: rtl/face_from_step.sv
// rtl/face_from_step.sv - entry face of the voxel reached by one DDA step
module face_from_step
   import ray_pkg::*;
(
   input  axis_t axis_i,
   input  logic  neg_i,
   output face_t face_o
);

   // A +axis step enters the new voxel through its -axis face, and vice versa.
   assign face_o = face_t'({axis_i, ~neg_i});

endmodule

// File: rtl/hit_face_encoder.sv
// rtl/hit_face_encoder.sv - tracks DDA step events per ray and emits the hit face_id
// Optional HIT_DEPTH_EN adds res_steps (accepted step count, including the terminating step).
module hit_face_encoder
   import ray_pkg::*;
#(
   parameter  int MAX_STEPS = 64,
   localparam int CNT_W     = $clog2(MAX_STEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ray_valid,
   output logic             ray_ready,
   input  logic             ray_start_solid,
   input  logic             step_valid,
   output logic             step_ready,
   input  logic [1:0]       step_axis,
   input  logic             step_neg,
   input  logic             step_solid,
   input  logic             step_oob,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [2:0]       res_face,
`ifdef HIT_DEPTH_EN
   output logic [CNT_W-1:0] res_steps,
`endif
   output logic             res_hit
);

   localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

   enc_state_t       state_q;
   logic             ray_ready_q;
   logic             step_ready_q;
   logic             res_valid_q;
   face_t            res_face_q;
   logic             res_hit_q;
   logic [CNT_W-1:0] step_cnt_q;
   logic [CNT_W-1:0] step_cnt_d;
`ifdef HIT_DEPTH_EN
   logic [CNT_W-1:0] res_steps_q;
`endif

   face_t step_face;
   logic  step_fire;
   logic  step_bad;
   logic  step_timeout;

   face_from_step u_face_from_step (
      .axis_i (axis_t'(step_axis)),
      .neg_i  (step_neg),
      .face_o (step_face)
   );

   assign step_fire    = step_valid && step_ready_q;
   assign step_cnt_d   = step_cnt_q + 1'b1;
   assign step_bad     = step_oob || (axis_t'(step_axis) == AXIS_ILLEGAL);
   assign step_timeout = (step_cnt_d == STEP_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ray_ready_q  <= 1'b1;
         step_ready_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_face_q   <= FACE_MISS;
         res_hit_q    <= 1'b0;
         step_cnt_q   <= '0;
`ifdef HIT_DEPTH_EN
         res_steps_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ray_valid && ray_ready_q) begin
                  step_cnt_q  <= '0;
                  ray_ready_q <= 1'b0;
                  if (ray_start_solid) begin
                     res_face_q  <= FACE_INSIDE;
                     res_hit_q   <= 1'b0;
                     res_valid_q <= 1'b1;
`ifdef HIT_DEPTH_EN
                     res_steps_q <= '0;
`endif
                     state_q     <= ST_HOLD;
                  end else begin
                     step_ready_q <= 1'b1;
                     state_q      <= ST_TRACE;
                  end
               end
            end
            ST_TRACE: begin
               if (step_fire) begin
                  if (step_bad || step_solid || step_timeout) begin
                     // Out-of-grid / illegal axis outrank a solid voxel on the same step.
                     res_face_q   <= (step_solid && !step_bad) ? step_face : FACE_MISS;
                     res_hit_q    <= step_solid && !step_bad;
                     res_valid_q  <= 1'b1;
                     step_ready_q <= 1'b0;
`ifdef HIT_DEPTH_EN
                     res_steps_q  <= step_cnt_d;
`endif
                     state_q      <= ST_HOLD;
                  end else begin
                     step_cnt_q <= step_cnt_d;
                  end
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  ray_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               ray_ready_q  <= 1'b1;
               step_ready_q <= 1'b0;
               res_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ray_ready  = ray_ready_q;
   assign step_ready = step_ready_q;
   assign res_valid  = res_valid_q;
   assign res_face   = res_face_q;
   assign res_hit    = res_hit_q;
`ifdef HIT_DEPTH_EN
   assign res_steps  = res_steps_q;
`endif

endmodule
